// File: rtl/vga_pkg.sv
// Shared pixel types and colour constants for the bouncing-sprite pixel stage.
package vga_pkg;

  // 2 bits per channel, matching the TinyVGA PMOD.
  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb222_t;

  localparam rgb222_t BLACK_RGB = '{r: 2'b00, g: 2'b00, b: 2'b00};
  localparam rgb222_t GRID_RGB  = '{r: 2'b01, g: 2'b01, b: 2'b01};

  // Sprite colours, stepped through on every wall hit.
  localparam rgb222_t [0:7] PALETTE = '{
    '{r: 2'b11, g: 2'b00, b: 2'b00},
    '{r: 2'b00, g: 2'b11, b: 2'b00},
    '{r: 2'b00, g: 2'b00, b: 2'b11},
    '{r: 2'b11, g: 2'b11, b: 2'b00},
    '{r: 2'b00, g: 2'b11, b: 2'b11},
    '{r: 2'b11, g: 2'b00, b: 2'b11},
    '{r: 2'b11, g: 2'b11, b: 2'b11},
    '{r: 2'b10, g: 2'b01, b: 2'b00}
  };

  // Colour lookup for a 3-bit palette index.
  function automatic rgb222_t palette_rgb(input logic [2:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/bounce_axis.sv
// One axis of sprite motion: position and direction, clamped bounce at 0 and MAX.
module bounce_axis #(
  parameter int MAX   = 608,
  parameter int START = 64
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       step_en_i,
  input  logic [2:0] speed_i,
  output logic [9:0] pos_o,
  output logic       hit_o
);

  localparam logic [9:0] MAX_C   = 10'(MAX);
  localparam logic [9:0] START_C = 10'(START);

  logic [9:0]  pos_q, pos_d;
  logic        dir_q, dir_d;
  logic        hit_d;
  logic [10:0] sum;

  assign sum = {1'b0, pos_q} + {8'b0, speed_i};

  // Next position/direction for one step; hit flags a wall contact this step.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    hit_d = 1'b0;
    if (step_en_i) begin
      if (dir_q) begin
        if (sum >= {1'b0, MAX_C}) begin
          pos_d = MAX_C;
          dir_d = 1'b0;
          hit_d = 1'b1;
        end else begin
          pos_d = sum[9:0];
        end
      end else begin
        if (pos_q <= {7'b0, speed_i}) begin
          pos_d = 10'd0;
          dir_d = 1'b1;
          hit_d = 1'b1;
        end else begin
          pos_d = pos_q - {7'b0, speed_i};
        end
      end
    end else begin
      pos_d = pos_q;
    end
  end

  // Position/direction state; starts moving towards increasing coordinates.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pos_q <= START_C;
      dir_q <= 1'b1;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos_o = pos_q;
  assign hit_o = hit_d;

endmodule

// File: rtl/vga_bounce_sprite.sv
// Pixel stage: square sprite over a grid, bouncing once per frame, with
// RGB and sync re-registered so every PMOD output has the same 2-cycle delay.
module vga_bounce_sprite
  import vga_pkg::*;
#(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int SPRITE_W        = 32,
  parameter int SPRITE_H        = 32,
  parameter int START_X         = 64,
  parameter int START_Y         = 48,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic [2:0] speed,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [1:0] r_out,
  output logic [1:0] g_out,
  output logic [1:0] b_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       bounce
);

  localparam logic       SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic       SYNC_OFF = ~SYNC_ON;
  localparam logic [9:0] SPR_W_C  = 10'(SPRITE_W);
  localparam logic [9:0] SPR_H_C  = 10'(SPRITE_H);

  // Frame tick: first cycle of vsync assertion. vsync_q resets asserted so a
  // reset released mid-vsync cannot fake an edge.
  logic vsync_q, tick, tick_q, step_en;
  assign tick    = (vsync_in == SYNC_ON) && (vsync_q == SYNC_OFF);
  assign step_en = tick_q & ~pause & (speed != 3'd0);

  // Vsync edge detector and one-cycle delayed tick that triggers the update.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q <= SYNC_ON;
      tick_q  <= 1'b0;
    end else begin
      vsync_q <= vsync_in;
      tick_q  <= tick;
    end
  end

  logic [9:0] x_pos, y_pos;
  logic       hit_x, hit_y;

  bounce_axis #(.MAX(H_ACTIVE - SPRITE_W), .START(START_X)) u_axis_x (
    .clk_i(clk), .reset_i(reset), .step_en_i(step_en), .speed_i(speed),
    .pos_o(x_pos), .hit_o(hit_x)
  );

  bounce_axis #(.MAX(V_ACTIVE - SPRITE_H), .START(START_Y)) u_axis_y (
    .clk_i(clk), .reset_i(reset), .step_en_i(step_en), .speed_i(speed),
    .pos_o(y_pos), .hit_o(hit_y)
  );

  logic [2:0] col_q, col_d;
  logic       bounce_q, bounce_d;

  // Colour advance on any hit; a corner hit still advances by one.
  always_comb begin
    col_d    = col_q;
    bounce_d = 1'b0;
    if (hit_x | hit_y) begin
      col_d    = col_q + 3'd1;
      bounce_d = 1'b1;
    end else begin
      col_d    = col_q;
    end
  end

  // Colour index and bounce pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q    <= 3'd0;
      bounce_q <= 1'b0;
    end else begin
      col_q    <= col_d;
      bounce_q <= bounce_d;
    end
  end

  // Stage 1: sprite/grid classification; wrapped differences land outside.
  logic [9:0] dx, dy;
  logic       in_spr_d;
  logic       in_spr_q, grid_q, de1_q, hs1_q, vs1_q;
  assign dx       = hpos - x_pos;
  assign dy       = vpos - y_pos;
  assign in_spr_d = display_on & (dx < SPR_W_C) & (dy < SPR_H_C);

  // Stage 1 pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_spr_q <= 1'b0;
      grid_q   <= 1'b0;
      de1_q    <= 1'b0;
      hs1_q    <= SYNC_OFF;
      vs1_q    <= SYNC_OFF;
    end else begin
      in_spr_q <= in_spr_d;
      grid_q   <= (hpos[4:0] == 5'd0) | (vpos[4:0] == 5'd0);
      de1_q    <= display_on;
      hs1_q    <= hsync_in;
      vs1_q    <= vsync_in;
    end
  end

  // Stage 2: colour select with blanking taking priority over the sprite.
  rgb222_t rgb_d, rgb_q;
  logic    hs2_q, vs2_q;
  always_comb begin
    rgb_d = BLACK_RGB;
    if (!de1_q) begin
      rgb_d = BLACK_RGB;
    end else if (in_spr_q) begin
      rgb_d = palette_rgb(col_q);
    end else if (grid_q) begin
      rgb_d = GRID_RGB;
    end else begin
      rgb_d = BLACK_RGB;
    end
  end

  // Stage 2 output registers, aligned with the delayed sync.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= BLACK_RGB;
      hs2_q <= SYNC_OFF;
      vs2_q <= SYNC_OFF;
    end else begin
      rgb_q <= rgb_d;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
    end
  end

  assign r_out     = rgb_q.r;
  assign g_out     = rgb_q.g;
  assign b_out     = rgb_q.b;
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;
  assign bounce    = bounce_q;

endmodule
